// File: rtl/noc_mmio_interface_if.sv
// Bus and network signal bundle for noc_mmio_interface.
// The slave modport is the network interface's view. The master modport is
// the combined CPU/router environment's view.
interface noc_mmio_interface_if #(
  parameter int COORD_BITS = 1
);
  // picorv32 look-ahead memory bus
  logic                  bus_read;
  logic                  bus_write;
  logic [31:0]           bus_addr;
  logic [31:0]           bus_wdata;
  logic [31:0]           bus_rdata;
  logic                  bus_hit;

  // Hoplite router port, outbound
  logic [31:0]           net_out_data;
  logic [COORD_BITS-1:0] net_out_x_dest;
  logic [COORD_BITS-1:0] net_out_y_dest;
  logic                  net_out_valid;
  logic                  net_out_ready;

  // Hoplite router port, inbound
  logic [31:0]           net_in_data;
  logic [COORD_BITS-1:0] net_in_x_src;
  logic [COORD_BITS-1:0] net_in_y_src;
  logic                  net_in_valid;
  logic                  net_in_ready;

  logic                  irq;

  modport slave (
    input  bus_read, bus_write, bus_addr, bus_wdata,
    input  net_out_ready,
    input  net_in_data, net_in_x_src, net_in_y_src, net_in_valid,
    output bus_rdata, bus_hit,
    output net_out_data, net_out_x_dest, net_out_y_dest, net_out_valid,
    output net_in_ready, irq
  );

  modport master (
    output bus_read, bus_write, bus_addr, bus_wdata,
    output net_out_ready,
    output net_in_data, net_in_x_src, net_in_y_src, net_in_valid,
    input  bus_rdata, bus_hit,
    input  net_out_data, net_out_x_dest, net_out_y_dest, net_out_valid,
    input  net_in_ready, irq
  );
endinterface

// File: rtl/noc_mmio_interface.sv
// Memory-mapped network interface between a picorv32 look-ahead bus and one
// Hoplite router port. It provides buffered TX/RX queues, a per-message
// destination, receive source tagging, sticky error flags, node-ID readback
// and a level interrupt.
module noc_mmio_interface #(
  parameter int          COORD_BITS = 1,
  parameter int          X_COORD    = 0,
  parameter int          Y_COORD    = 0,
  parameter int          TX_DEPTH   = 4,
  parameter int          RX_DEPTH   = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0100
) (
  input logic                clk,
  input logic                reset_n,
  noc_mmio_interface_if.slave io
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int TX_CW = $clog2(TX_DEPTH + 1);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int RX_CW = $clog2(RX_DEPTH + 1);

  localparam logic [2:0] REG_TX_DEST = 3'h0;
  localparam logic [2:0] REG_TX_DATA = 3'h1;
  localparam logic [2:0] REG_RX_DATA = 3'h2;
  localparam logic [2:0] REG_RX_SRC  = 3'h3;
  localparam logic [2:0] REG_STATUS  = 3'h4;
  localparam logic [2:0] REG_CONTROL = 3'h5;
  localparam logic [2:0] REG_NODE_ID = 3'h6;

  // One queued message. Field order matches the storage concatenations below.
  typedef struct packed {
    logic [COORD_BITS-1:0] x;
    logic [COORD_BITS-1:0] y;
    logic [31:0]           data;
  } entry_t;

  // Coordinates packed into the shared TX_DEST / RX_SRC / NODE_ID layout.
  function automatic logic [31:0] coord_word(input logic [COORD_BITS-1:0] x,
                                             input logic [COORD_BITS-1:0] y);
    logic [31:0] w;
    w                   = '0;
    w[COORD_BITS-1:0]   = x;
    w[16 +: COORD_BITS] = y;
    return w;
  endfunction

  // ---------------------------------------------------------------------------
  // Address decode. The base only needs to be word-aligned, so the window is
  // found by subtraction rather than by matching upper address bits.
  // ---------------------------------------------------------------------------
  logic [31:0] addr_off;
  logic        in_win;
  logic [2:0]  reg_sel;
  logic        rd_en;
  logic        wr_en;
  logic        unused_addr_bits;

  assign addr_off         = io.bus_addr - BASE_ADDR;
  assign in_win           = (addr_off[31:5] == 27'd0);
  assign reg_sel          = addr_off[4:2];
  assign unused_addr_bits = ^addr_off[1:0];
  assign rd_en            = io.bus_read  && in_win;
  assign wr_en            = io.bus_write && in_win;

  // ---------------------------------------------------------------------------
  // Control/status registers
  // ---------------------------------------------------------------------------
  logic [COORD_BITS-1:0] tx_dest_x;
  logic [COORD_BITS-1:0] tx_dest_y;
  logic                  irq_en;
  logic                  tx_overflow;
  logic                  rx_underflow;
  logic                  status_wr;

  assign status_wr = wr_en && (reg_sel == REG_STATUS);

  // ---------------------------------------------------------------------------
  // TX FIFO (first-word fall-through towards the router)
  // ---------------------------------------------------------------------------
  entry_t            tx_mem [TX_DEPTH];
  entry_t            tx_head;
  logic [TX_AW-1:0]  tx_wr_ptr;
  logic [TX_AW-1:0]  tx_rd_ptr;
  logic [TX_CW-1:0]  tx_count;
  logic              tx_empty;
  logic              tx_full;
  logic              tx_write;
  logic              tx_push;
  logic              tx_pop;
  logic              tx_drop;

  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == TX_CW'(TX_DEPTH));
  assign tx_pop   = !tx_empty && io.net_out_ready;
  assign tx_write = wr_en && (reg_sel == REG_TX_DATA);
  // A full FIFO still takes the write when the head leaves on the same edge.
  assign tx_push  = tx_write && (!tx_full || tx_pop);
  assign tx_drop  = tx_write && tx_full && !tx_pop;
  assign tx_head  = tx_mem[tx_rd_ptr];

  // TX storage write.
  // NOTE: FIFO storage has no reset; the count gates every use of its contents.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= {tx_dest_x, tx_dest_y, io.bus_wdata};
  end

  // TX pointers and occupancy.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + TX_CW'(1);
        2'b01:   tx_count <= tx_count - TX_CW'(1);
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // RX FIFO (filled by the router, drained by RX_DATA reads)
  // ---------------------------------------------------------------------------
  entry_t            rx_mem [RX_DEPTH];
  entry_t            rx_head;
  logic [RX_AW-1:0]  rx_wr_ptr;
  logic [RX_AW-1:0]  rx_rd_ptr;
  logic [RX_CW-1:0]  rx_count;
  logic              rx_empty;
  logic              rx_full;
  logic              rx_read;
  logic              rx_push;
  logic              rx_pop;
  logic              rx_miss;

  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == RX_CW'(RX_DEPTH));
  assign rx_read  = rd_en && (reg_sel == REG_RX_DATA);
  assign rx_pop   = rx_read && !rx_empty;
  // Reading an empty FIFO underflows even if a word arrives on the same edge.
  assign rx_miss  = rx_read && rx_empty;
  assign rx_push  = io.net_in_valid && !rx_full;
  assign rx_head  = rx_mem[rx_rd_ptr];

  // RX storage write.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= {io.net_in_x_src, io.net_in_y_src, io.net_in_data};
  end

  // RX pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + RX_CW'(1);
        2'b01:   rx_count <= rx_count - RX_CW'(1);
        default: ;
      endcase
    end
  end

  // Writable registers and sticky flags; a hardware set beats a W1C clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_dest_x    <= '0;
      tx_dest_y    <= '0;
      irq_en       <= 1'b0;
      tx_overflow  <= 1'b0;
      rx_underflow <= 1'b0;
    end else begin
      if (wr_en && (reg_sel == REG_TX_DEST)) begin
        tx_dest_x <= io.bus_wdata[COORD_BITS-1:0];
        tx_dest_y <= io.bus_wdata[16 +: COORD_BITS];
      end
      if (wr_en && (reg_sel == REG_CONTROL)) irq_en <= io.bus_wdata[0];
      tx_overflow  <= tx_drop || (tx_overflow  && !(status_wr && io.bus_wdata[3]));
      rx_underflow <= rx_miss || (rx_underflow && !(status_wr && io.bus_wdata[4]));
    end
  end

  // ---------------------------------------------------------------------------
  // Read path: select from pre-edge state, register on the read edge.
  // ---------------------------------------------------------------------------
  logic [31:0] rdata_next;
  logic [31:0] bus_rdata_q;
  logic        bus_hit_q;
  logic        irq_q;

  // Read data mux.
  // NOTE: assigning a default first keeps every path driven, so no latch.
  always_comb begin
    rdata_next = '0;
    case (reg_sel)
      REG_TX_DEST: rdata_next = coord_word(tx_dest_x, tx_dest_y);
      REG_RX_DATA: rdata_next = rx_empty ? '0 : rx_head.data;
      REG_RX_SRC:  rdata_next = rx_empty ? '0 : coord_word(rx_head.x, rx_head.y);
      REG_STATUS:  rdata_next = {8'd0, 8'(tx_count), 8'(rx_count), 3'd0,
                                 rx_underflow, tx_overflow, tx_empty, tx_full, !rx_empty};
      REG_CONTROL: rdata_next = {31'd0, irq_en};
      REG_NODE_ID: rdata_next = coord_word(COORD_BITS'(X_COORD), COORD_BITS'(Y_COORD));
      default:     rdata_next = '0;
    endcase
  end

  // Registered bus response and interrupt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_rdata_q <= '0;
      bus_hit_q   <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      bus_hit_q <= rd_en;
      if (rd_en) bus_rdata_q <= rdata_next;
      irq_q <= irq_en && !rx_empty;
    end
  end

  assign io.bus_rdata      = bus_rdata_q;
  assign io.bus_hit        = bus_hit_q;
  assign io.irq            = irq_q;
  assign io.net_in_ready   = !rx_full;
  assign io.net_out_valid  = !tx_empty;
  assign io.net_out_data   = tx_empty ? '0 : tx_head.data;
  assign io.net_out_x_dest = tx_empty ? '0 : tx_head.x;
  assign io.net_out_y_dest = tx_empty ? '0 : tx_head.y;

endmodule
